// File: rtl/alu_defs_pkg.sv
// Shared encodings for the ALU control sequencer: funct fields, ALU control
// codes, multiply/divide operation codes and the sequencer state.
package alu_defs_pkg;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  localparam logic [4:0] AC_AND  = 5'd0;
  localparam logic [4:0] AC_OR   = 5'd1;
  localparam logic [4:0] AC_ADD  = 5'd2;
  localparam logic [4:0] AC_SLL  = 5'd3;
  localparam logic [4:0] AC_SRL  = 5'd4;
  localparam logic [4:0] AC_SUB  = 5'd6;
  localparam logic [4:0] AC_SLT  = 5'd7;
  localparam logic [4:0] AC_ADDU = 5'd8;
  localparam logic [4:0] AC_SUBU = 5'd9;
  localparam logic [4:0] AC_XOR  = 5'd10;
  localparam logic [4:0] AC_SLTU = 5'd11;
  localparam logic [4:0] AC_NOR  = 5'd12;
  localparam logic [4:0] AC_SRA  = 5'd13;
  localparam logic [4:0] AC_MFHI = 5'd16;
  localparam logic [4:0] AC_MFLO = 5'd17;

  localparam logic [1:0] MDOP_MULT  = 2'b00;
  localparam logic [1:0] MDOP_MULTU = 2'b01;
  localparam logic [1:0] MDOP_DIV   = 2'b10;
  localparam logic [1:0] MDOP_DIVU  = 2'b11;

  localparam int CNT_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } seq_state_e;

endpackage

// File: rtl/alu_func_decode.sv
// Combinational ALUop/funct decode: ALU control code plus classification of
// the request (illegal funct, multiply/divide launch, HI/LO read).
module alu_func_decode
  import alu_defs_pkg::*;
#(
  parameter int OPW   = 4,
  parameter int CTRLW = 5
) (
  input  logic [OPW-1:0]   i_alu_op,
  input  logic [5:0]       i_funct,
  output logic [CTRLW-1:0] o_ctrl,
  output logic             o_illegal,
  output logic             o_md,
  output logic             o_hilo,
  output logic [1:0]       o_md_op
);

  logic [4:0] w_rcode;

  always_comb begin
    o_ctrl    = '0;
    o_illegal = 1'b0;
    o_md      = 1'b0;
    o_hilo    = 1'b0;
    o_md_op   = MDOP_MULT;
    w_rcode   = AC_AND;
    if (&i_alu_op) begin
      case (i_funct)
        FN_SLL:   w_rcode = AC_SLL;
        FN_SRL:   w_rcode = AC_SRL;
        FN_SRA:   w_rcode = AC_SRA;
        FN_ADD:   w_rcode = AC_ADD;
        FN_ADDU:  w_rcode = AC_ADDU;
        FN_SUB:   w_rcode = AC_SUB;
        FN_SUBU:  w_rcode = AC_SUBU;
        FN_AND:   w_rcode = AC_AND;
        FN_OR:    w_rcode = AC_OR;
        FN_XOR:   w_rcode = AC_XOR;
        FN_NOR:   w_rcode = AC_NOR;
        FN_SLT:   w_rcode = AC_SLT;
        FN_SLTU:  w_rcode = AC_SLTU;
        FN_MFHI:  begin w_rcode = AC_MFHI; o_hilo = 1'b1; end
        FN_MFLO:  begin w_rcode = AC_MFLO; o_hilo = 1'b1; end
        FN_MULT:  begin o_md = 1'b1; o_md_op = MDOP_MULT;  end
        FN_MULTU: begin o_md = 1'b1; o_md_op = MDOP_MULTU; end
        FN_DIV:   begin o_md = 1'b1; o_md_op = MDOP_DIV;   end
        FN_DIVU:  begin o_md = 1'b1; o_md_op = MDOP_DIVU;  end
        default:  o_illegal = 1'b1;
      endcase
      o_ctrl = CTRLW'(w_rcode);
    end else begin
      o_ctrl = CTRLW'(i_alu_op);
    end
  end

endmodule

// File: rtl/pipelined_alu_sequencer.sv
// ALU control sequencer: one-cycle registered decode plus a multiply/divide
// occupancy tracker that stalls dependent requests while the unit is busy.
//   state   | meaning
//   IDLE    | multiply/divide unit free
//   BUSY    | MD op in flight; counter counts down to 0, MDDone on 0
module pipelined_alu_sequencer
  import alu_defs_pkg::*;
#(
  parameter int OPW        = 4,
  parameter int CTRLW      = 5,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic             CLK,
  input  logic             Reset_L,
  input  logic             InValid,
  input  logic [OPW-1:0]   ALUop,
  input  logic [5:0]       FuncCode,
  input  logic             Flush,
  output logic             InReady,
  output logic             OutValid,
  output logic [CTRLW-1:0] ALUCtrl,
  output logic             IllegalFunc,
  output logic             MDStart,
  output logic [1:0]       MDOp,
  output logic             Busy,
  output logic             MDDone
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  seq_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CTRLW-1:0] w_ctrl;
  logic             w_illegal, w_md, w_hilo, w_accept;
  logic [1:0]       w_md_op;

  alu_func_decode #(.OPW(OPW), .CTRLW(CTRLW)) u_decode (
    .i_alu_op  (ALUop),
    .i_funct   (FuncCode),
    .o_ctrl    (w_ctrl),
    .o_illegal (w_illegal),
    .o_md      (w_md),
    .o_hilo    (w_hilo),
    .o_md_op   (w_md_op)
  );

  assign w_accept = InValid & InReady & ~Flush;

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE:
        if (w_accept && w_md) begin
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = w_md_op[1] ? DIV_LOAD : MUL_LOAD;
        end
      ST_BUSY:
        if (r_cnt == '0) w_state_nxt = ST_IDLE;
        else             w_cnt_nxt   = r_cnt - CNT_ONE;
    endcase
  end

  // HI/LO readers wait with MD ops so they never observe a partial result
  always_comb begin
    Busy    = (r_state == ST_BUSY);
    MDDone  = Busy && (r_cnt == '0);
    InReady = !(Busy && (w_md || w_hilo));
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      OutValid    <= 1'b0;
      ALUCtrl     <= '0;
      IllegalFunc <= 1'b0;
      MDStart     <= 1'b0;
      MDOp        <= '0;
    end else begin
      OutValid    <= w_accept;
      ALUCtrl     <= w_accept ? w_ctrl : '0;
      IllegalFunc <= w_accept & w_illegal;
      MDStart     <= w_accept & w_md;
      MDOp        <= (w_accept && w_md) ? w_md_op : MDOP_MULT;
    end
  end

endmodule

// File: tb/tb_pipelined_alu_sequencer.sv
// Bench for pipelined_alu_sequencer: decode vector table, directed
// multi-cycle sequences, then random traffic against a cycle-count model.
module tb_pipelined_alu_sequencer;

  localparam int MULN = 4;
  localparam int DIVN = 32;

  logic       CLK = 1'b0;
  logic       Reset_L = 1'b0;
  logic       InValid = 1'b0;
  logic       Flush = 1'b0;
  logic [3:0] ALUop = '0;
  logic [5:0] FuncCode = '0;
  logic       InReady, OutValid, IllegalFunc, MDStart, Busy, MDDone;
  logic [4:0] ALUCtrl;
  logic [1:0] MDOp;

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  pipelined_alu_sequencer #(
    .OPW(4), .CTRLW(5), .MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)
  ) dut (
    .CLK(CLK), .Reset_L(Reset_L), .InValid(InValid), .ALUop(ALUop),
    .FuncCode(FuncCode), .Flush(Flush), .InReady(InReady),
    .OutValid(OutValid), .ALUCtrl(ALUCtrl), .IllegalFunc(IllegalFunc),
    .MDStart(MDStart), .MDOp(MDOp), .Busy(Busy), .MDDone(MDDone)
  );

  // Legal non-MD R-type funct values and their ALU control codes
  int rtab_fn[15]   = '{0, 2, 3, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 16, 18};
  int rtab_code[15] = '{3, 4, 13, 2, 8, 6, 9, 0, 1, 10, 12, 7, 11, 16, 17};
  int fn_pool[22]   = '{0, 2, 3, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 16, 18,
                        24, 25, 26, 27, 63, 1, 28};

  typedef struct {
    logic [3:0] op;
    logic [5:0] fn;
    bit         fl;
    bit         ev;
    int         ectrl;
    bit         eill;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input bit v, input logic [3:0] op, input logic [5:0] fn, input bit fl);
    InValid  = v;
    ALUop    = op;
    FuncCode = fn;
    Flush    = fl;
  endtask

  function automatic void ref_decode(input logic [3:0] op, input logic [5:0] fn,
                                     output int ctrl, output bit ill,
                                     output bit md, output bit hilo);
    ctrl = 0; ill = 0; md = 0; hilo = 0;
    if (op != 4'hF) begin
      ctrl = int'(op);
      return;
    end
    if (fn >= 6'd24 && fn <= 6'd27) begin
      md = 1;
      return;
    end
    for (int i = 0; i < 15; i++) begin
      if (rtab_fn[i] == int'(fn)) begin
        ctrl = rtab_code[i];
        hilo = (ctrl >= 16);
        return;
      end
    end
    ill = 1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n_busy, n_done, done_at, stalls;
    bit got_ready;
    int busy_left;

    // reset state
    #2;
    check("reset OutValid", OutValid, 0);
    check("reset ALUCtrl", ALUCtrl, 0);
    check("reset MDStart", MDStart, 0);
    check("reset Busy", Busy, 0);
    check("reset MDDone", MDDone, 0);
    check("reset InReady", InReady, 1);
    step();
    Reset_L = 1'b1;
    step();
    step();

    // decode vector table: {op, fn, flush, exp valid, exp ctrl, exp illegal}
    vt.push_back('{4'b0010, 6'd0,  0, 1, 2,  0});
    vt.push_back('{4'b0000, 6'd5,  0, 1, 0,  0});
    vt.push_back('{4'b0111, 6'd63, 0, 1, 7,  0});
    vt.push_back('{4'b1110, 6'd24, 0, 1, 14, 0});
    vt.push_back('{4'hF, 6'b000000, 0, 1, 3,  0});
    vt.push_back('{4'hF, 6'b000010, 0, 1, 4,  0});
    vt.push_back('{4'hF, 6'b000011, 0, 1, 13, 0});
    vt.push_back('{4'hF, 6'b100000, 0, 1, 2,  0});
    vt.push_back('{4'hF, 6'b100001, 0, 1, 8,  0});
    vt.push_back('{4'hF, 6'b100010, 0, 1, 6,  0});
    vt.push_back('{4'hF, 6'b100011, 0, 1, 9,  0});
    vt.push_back('{4'hF, 6'b100100, 0, 1, 0,  0});
    vt.push_back('{4'hF, 6'b100101, 0, 1, 1,  0});
    vt.push_back('{4'hF, 6'b100110, 0, 1, 10, 0});
    vt.push_back('{4'hF, 6'b100111, 0, 1, 12, 0});
    vt.push_back('{4'hF, 6'b101010, 0, 1, 7,  0});
    vt.push_back('{4'hF, 6'b101011, 0, 1, 11, 0});
    vt.push_back('{4'hF, 6'b010000, 0, 1, 16, 0});
    vt.push_back('{4'hF, 6'b010010, 0, 1, 17, 0});
    vt.push_back('{4'hF, 6'b111111, 0, 1, 0,  1});
    vt.push_back('{4'hF, 6'b000001, 0, 1, 0,  1});
    vt.push_back('{4'hF, 6'b011100, 0, 1, 0,  1});
    vt.push_back('{4'b0010, 6'd0,   1, 0, 0,  0});
    vt.push_back('{4'hF, 6'b111111, 1, 0, 0,  0});

    for (int i = 0; i < vt.size(); i++) begin
      drive(1, vt[i].op, vt[i].fn, vt[i].fl);
      step();
      check($sformatf("vec%0d OutValid", i), OutValid, vt[i].ev);
      check($sformatf("vec%0d ALUCtrl", i), ALUCtrl, vt[i].ectrl);
      check($sformatf("vec%0d IllegalFunc", i), IllegalFunc, vt[i].eill);
      check($sformatf("vec%0d MDStart", i), MDStart, 0);
    end
    drive(0, 4'b0010, 6'd0, 0);
    step();
    check("idle OutValid", OutValid, 0);
    check("idle ALUCtrl", ALUCtrl, 0);

    // back-to-back NOR then SLT
    drive(1, 4'hF, 6'b100111, 0);
    step();
    check("b2b first ctrl", ALUCtrl, 12);
    drive(1, 4'hF, 6'b101010, 0);
    step();
    check("b2b second ctrl", ALUCtrl, 7);
    check("b2b second valid", OutValid, 1);
    drive(0, 4'h0, 6'd0, 0);
    step();

    // DIV: busy 32 cycles, MDDone on the 32nd
    drive(1, 4'hF, 6'b011010, 0);
    #1;
    check("div InReady", InReady, 1);
    step();
    drive(0, 4'h0, 6'd0, 0);
    check("div MDStart", MDStart, 1);
    check("div MDOp", MDOp, 2);
    check("div OutValid", OutValid, 1);
    check("div ALUCtrl", ALUCtrl, 0);
    n_busy = 0; n_done = 0; done_at = 0;
    for (int c = 1; c <= 100 && Busy; c++) begin
      n_busy++;
      if (MDDone) begin
        n_done++;
        done_at = c;
      end
      step();
    end
    check("div busy cycles", n_busy, DIVN);
    check("div MDDone cycle", done_at, DIVN);
    check("div MDDone count", n_done, 1);
    check("div Busy after", Busy, 0);
    check("div MDDone after", MDDone, 0);

    // MFLO stalled behind a MULT
    drive(1, 4'hF, 6'b011000, 0);
    step();
    check("mult MDStart", MDStart, 1);
    check("mult MDOp", MDOp, 0);
    drive(1, 4'hF, 6'b010010, 0);
    stalls = 0; got_ready = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (InReady) begin
        got_ready = 1;
        break;
      end
      stalls++;
      step();
    end
    check("mflo got ready", got_ready, 1);
    check("mflo stall cycles", stalls, MULN);
    step();
    drive(0, 4'h0, 6'd0, 0);
    check("mflo OutValid", OutValid, 1);
    check("mflo ALUCtrl", ALUCtrl, 17);

    // flushed DIV never launches
    drive(1, 4'hF, 6'b011010, 1);
    step();
    drive(0, 4'h0, 6'd0, 0);
    check("flush MDStart", MDStart, 0);
    check("flush OutValid", OutValid, 0);
    check("flush Busy", Busy, 0);
    step();
    check("flush Busy later", Busy, 0);

    // reset mid-DIV at counter 10, then a fresh MULT
    drive(1, 4'hF, 6'b011011, 0);
    step();
    drive(0, 4'h0, 6'd0, 0);
    repeat (DIVN - 1 - 10) step();
    check("middiv Busy before reset", Busy, 1);
    #2;
    Reset_L = 1'b0;
    #1;
    check("middiv Busy in reset", Busy, 0);
    check("middiv MDDone in reset", MDDone, 0);
    check("middiv InReady in reset", InReady, 1);
    check("middiv OutValid in reset", OutValid, 0);
    check("middiv MDOp in reset", MDOp, 0);
    for (int c = 0; c < 2; c++) begin
      step();
      check("middiv MDDone held", MDDone, 0);
    end
    #3;
    Reset_L = 1'b1;
    step();
    check("post reset MDStart", MDStart, 0);
    check("post reset Busy", Busy, 0);
    drive(1, 4'hF, 6'b011000, 0);
    step();
    drive(0, 4'h0, 6'd0, 0);
    check("post reset mult MDStart", MDStart, 1);
    check("post reset mult Busy", Busy, 1);
    repeat (MULN + 2) step();
    check("post reset mult done", Busy, 0);

    // random traffic against cycle-count model
    busy_left = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic [3:0]  op;
      logic [5:0]  fn;
      bit          v, fl, ill, md, hilo, exp_ready, acc;
      int          ctrl;
      logic [31:0] expv, gotv;
      logic [1:0]  emdop;
      v  = ($urandom_range(0, 9) < 8);
      fl = ($urandom_range(0, 9) == 0);
      op = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'(fn_pool[$urandom_range(0, 21)]);
      drive(v, op, fn, fl);
      #1;
      ref_decode(op, fn, ctrl, ill, md, hilo);
      exp_ready = !((busy_left > 0) && (md || hilo));
      acc = v && exp_ready && !fl;
      check($sformatf("rand%0d InReady", cyc), InReady, exp_ready);
      step();
      if (acc && md) busy_left = fn[1] ? DIVN : MULN;
      else if (busy_left > 0) busy_left--;
      emdop = (acc && md) ? fn[1:0] : 2'b00;
      expv = {20'd0, acc, (acc ? 5'(ctrl) : 5'd0), (acc && ill), (acc && md), emdop,
              (busy_left > 0), (busy_left == 1)};
      gotv = {20'd0, OutValid, ALUCtrl, IllegalFunc, MDStart, MDOp, Busy, MDDone};
      check($sformatf("rand%0d outputs", cyc), gotv, expv);
    end
    drive(0, 4'h0, 6'd0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_alu_sequencer.md
PIPELINED_ALU_SEQUENCER -- requirements
Module: pipelined_alu_sequencer

Interface
REQ-001 SHALL have parameter OPW, default 4, ALUop width; the all-ones ALUop value means R-type.
REQ-002 SHALL have parameter CTRLW, default 5, ALUCtrl width; CTRLW >= OPW.
REQ-003 SHALL have parameter MUL_CYCLES, default 4, multiply busy length in cycles; range 1..255.
REQ-004 SHALL have parameter DIV_CYCLES, default 32, divide busy length in cycles; range 1..255.
REQ-005 SHALL have port CLK  in  1  sole clock; all state on its rising edge.
REQ-006 SHALL have port Reset_L  in  1  asynchronous active-low reset.
REQ-007 SHALL have port InValid  in  1  decode request valid.
REQ-008 SHALL have port ALUop  in  OPW  main-control ALU operation.
REQ-009 SHALL have port FuncCode  in  6  instruction funct field.
REQ-010 SHALL have port Flush  in  1  squash the request this cycle and the output register.
REQ-011 SHALL have port InReady  out  1  request accepted when InValid & InReady & ~Flush.
REQ-012 SHALL have port OutValid  out  1  registered ALUCtrl valid.
REQ-013 SHALL have port ALUCtrl  out  CTRLW  registered ALU control code.
REQ-014 SHALL have port IllegalFunc  out  1  registered unknown-funct flag.
REQ-015 SHALL have port MDStart  out  1  one-cycle multiply/divide launch pulse.
REQ-016 SHALL have port MDOp  out  2  MULT=00, MULTU=01, DIV=10, DIVU=11; valid with MDStart.
REQ-017 SHALL have port Busy  out  1  multiply/divide unit occupied.
REQ-018 SHALL have port MDDone  out  1  one-cycle completion pulse.

Function
REQ-019 Latency SHALL be one cycle: an accept at edge t drives OutValid=1 and the outputs after edge t+1; a non-accept cycle drives OutValid=0, ALUCtrl=0, IllegalFunc=0.
REQ-020 A non-R-type ALUop SHALL yield ALUCtrl = the zero-extended ALUop.
REQ-021 R-type funct decode SHALL be SLL 000000->3, SRL 000010->4, SRA 000011->13, ADD 100000->2, ADDU 100001->8, SUB 100010->6, SUBU 100011->9, AND 100100->0, OR 100101->1, XOR 100110->10, NOR 100111->12, SLT 101010->7, SLTU 101011->11, MFHI 010000->16, MFLO 010010->17 (zero-extended to CTRLW).
REQ-022 MULT/MULTU/DIV/DIVU (011000..011011) SHALL yield ALUCtrl=0 and MDStart=1 with MDOp = funct[1:0], aligned with OutValid.
REQ-023 Any other R-type funct SHALL yield ALUCtrl=0 and IllegalFunc=1; no X is ever driven.
REQ-024 The FSM SHALL have two states, IDLE and BUSY; IDLE->BUSY on an accepted MD op; BUSY->IDLE when the counter reads 0.
REQ-025 On entry to BUSY the counter SHALL load (MUL_CYCLES or DIV_CYCLES)-1; it decrements each BUSY cycle; MDDone=1 in the BUSY cycle where the counter reads 0.
REQ-026 Busy SHALL equal (state==BUSY): for an accept at edge t it is high t+1..t+N and low from t+N+1.
REQ-027 InReady SHALL be 0 while Busy when the request is an MD op, MFHI or MFLO; otherwise InReady=1.
REQ-028 Flush SHALL drop the current request and clear OutValid/MDStart/IllegalFunc/ALUCtrl at the next edge; an in-flight BUSY SHALL run to completion.
REQ-029 The earliest back-to-back MD accept SHALL be the edge after MDDone.

Reset
REQ-030 Reset_L low SHALL immediately force all outputs to 0, except InReady=1 when Busy=0; the state returns to IDLE and the counter to 0.
REQ-031 A reset during BUSY SHALL abort the operation with no MDDone.
REQ-032 Reset deassertion SHALL take effect at the next CLK edge with no spurious pulse.

Structure
REQ-033 The funct codes, ALUCtrl codes, MDOp encodings and FSM state encoding SHALL live in the shared package alu_defs_pkg.
REQ-034 Combinational decoding SHALL be in the sub-module alu_func_decode; the FSM, counter and output register SHALL be in the top.

Verification
REQ-035 ALUop=4'b0010, InValid=1 -> next cycle OutValid=1, ALUCtrl=5'd2, IllegalFunc=0.
REQ-036 ALUop=4'b1111, funct=100111, then 101010 on consecutive cycles -> ALUCtrl 12, then 7, back-to-back.
REQ-037 ALUop=4'b1111, funct=011010 -> MDStart=1, MDOp=10, Busy high 32 cycles, MDDone on cycle 32, Busy=0 on cycle 33.
REQ-038 During a MULT (MUL_CYCLES=4), present MFLO -> InReady=0 for 4 cycles, accepted the cycle after MDDone, then ALUCtrl=17.
REQ-039 funct=111111 R-type -> IllegalFunc=1, ALUCtrl=0; Flush with DIV valid -> no MDStart, Busy stays 0.
REQ-040 Assert Reset_L=0 mid-DIV at counter=10 -> Busy=0 immediately, no MDDone; a new MULT is accepted after release.
